// File: rtl/lcd_status_reader.sv
// HD44780 8-bit read-cycle engine: status (BF+AC) and DDRAM data reads, with optional busy polling.
// Define LCD_POLL_TIMEOUT_EN to bound busy polling by TIMEOUT_CYC cycles and report it on oTimeout.
module lcd_status_reader #(
    parameter int CLK_DIVIDE  = 16,
    parameter int SETUP_CYC   = 2,
    parameter int HOLD_CYC    = 2,
    parameter int POLL_GAP    = 32,
    parameter int TIMEOUT_CYC = 262143
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iStart,
    input  logic       iRS,
    input  logic       iPoll,
    output logic       oDone,
    output logic [7:0] oData,
    output logic       oBusy,
    output logic [6:0] oAddr,
    output logic       oTimeout,
    output logic       oActive,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS,
    inout  wire  [7:0] LCD_DATA
);

    localparam int ENH_CYC = CLK_DIVIDE + 1;
    localparam int MAX_A   = (ENH_CYC > SETUP_CYC) ? ENH_CYC : SETUP_CYC;
    localparam int MAX_B   = (HOLD_CYC > POLL_GAP) ? HOLD_CYC : POLL_GAP;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ENH_LD   = CNT_W'(ENH_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(POLL_GAP - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_ENH   = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic             poll_q, poll_d;
    logic             start_prev_q, start_prev_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic [6:0]       addr_q, addr_d;
    logic             done_q, done_d;
    logic             active_q, active_d;
    logic             rw_q, rw_d;
    logic             en_q, en_d;
    logic             lcd_rs_q, lcd_rs_d;
    logic             start_evt;
    logic             cnt_zero;
    logic             timed_out;

    assign start_evt = (state_q == S_IDLE) && !start_prev_q && iStart;
    assign cnt_zero  = (cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
        rs_d         = rs_q;
        poll_d       = poll_q;
        start_prev_d = iStart;
        data_d       = data_q;
        busy_d       = busy_q;
        addr_d       = addr_q;

        case (state_q)
            S_IDLE: begin
                if (start_evt) begin
                    rs_d    = iRS & ~iPoll;
                    poll_d  = iPoll;
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    state_d = S_ENH;
                    cnt_d   = ENH_LD;
                end
            end
            S_ENH: begin
                // Sample on the last EN-high cycle, while the LCD still drives the bus.
                if (cnt_zero) begin
                    data_d = LCD_DATA;
                    if (!rs_q) begin
                        busy_d = LCD_DATA[7];
                        addr_d = LCD_DATA[6:0];
                    end
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    if (poll_q && busy_q && !timed_out) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LD;
                    end else begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Bus pins are registered decodes of the current state, so they trail state_q by one cycle.
        active_d = (state_q == S_SETUP) || (state_q == S_ENH) ||
                   (state_q == S_HOLD)  || (state_q == S_GAP);
        rw_d     = (state_q == S_SETUP) || (state_q == S_ENH) || (state_q == S_HOLD);
        en_d     = (state_q == S_ENH);
        lcd_rs_d = rw_d & rs_q;
        done_d   = (state_q == S_DONE);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rs_q         <= 1'b0;
            poll_q       <= 1'b0;
            start_prev_q <= 1'b0;
            data_q       <= 8'h00;
            busy_q       <= 1'b0;
            addr_q       <= 7'h00;
            done_q       <= 1'b0;
            active_q     <= 1'b0;
            rw_q         <= 1'b0;
            en_q         <= 1'b0;
            lcd_rs_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rs_q         <= rs_d;
            poll_q       <= poll_d;
            start_prev_q <= start_prev_d;
            data_q       <= data_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            done_q       <= done_d;
            active_q     <= active_d;
            rw_q         <= rw_d;
            en_q         <= en_d;
            lcd_rs_q     <= lcd_rs_d;
        end
    end

`ifdef LCD_POLL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;

    assign timed_out = (tmo_cnt_q == TMO_LIM);

    // Saturating cycle counter; a timeout only takes effect at a busy HOLD exit.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = timeout_q;
        if (start_evt) begin
            tmo_cnt_d = '0;
            timeout_d = 1'b0;
        end else if (poll_q && !timed_out) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
        if ((state_q == S_HOLD) && cnt_zero && poll_q && busy_q && timed_out) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign oTimeout = timeout_q;
`else
    assign timed_out = 1'b0;
    assign oTimeout  = 1'b0;
`endif

    assign oDone   = done_q;
    assign oData   = data_q;
    assign oBusy   = busy_q;
    assign oAddr   = addr_q;
    assign oActive = active_q;
    assign LCD_RW  = rw_q;
    assign LCD_EN  = en_q;
    assign LCD_RS  = lcd_rs_q;

endmodule

// File: tb/tb_lcd_status_reader.sv
// Self-checking bench for lcd_status_reader: table vectors, random transactions against a
// transaction-level model of an HD44780 responder, and hand-written corner sequences.
module tb_lcd_status_reader;

    localparam int CD  = 16;
    localparam int SU  = 2;
    localparam int HO  = 2;
    localparam int GAP = 32;
    localparam int TMO = 100;
    localparam int BASE_LAT = SU + CD + 1 + HO + 1;
    localparam int ITER     = GAP + SU + CD + 1 + HO;
`ifdef LCD_POLL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        logic       rs;
        logic       poll;
        logic [7:0] b;
        int         nbusy;
        logic [7:0] exp_data;
        logic       exp_busy;
        logic [6:0] exp_addr;
        int         exp_lat;
        int         exp_pulses;
        logic       exp_to;
    } vec_t;

    logic       iCLK = 1'b0;
    logic       iRST_N = 1'b0;
    logic       iStart = 1'b0;
    logic       iRS = 1'b0;
    logic       iPoll = 1'b0;
    logic       oDone, oBusy, oTimeout, oActive, LCD_RW, LCD_EN, LCD_RS;
    logic [7:0] oData;
    logic [6:0] oAddr;
    wire  [7:0] LCD_DATA;

    logic [7:0] data_byte = 8'h00;
    logic [7:0] stat_arr [8];
    int         stat_base = 0;
    int         stat_n = 1;
    logic [7:0] status_cur;

    int   stat_reads = 0, en_pulses = 0, done_cnt = 0, gap_cycles = 0;
    int   rs_cycles = 0, bad_len = 0, en_run = 0;
    logic en_prev = 1'b0;

    int n_checks = 0;
    int n_fail = 0;
    int txn_no = 0;

    logic [7:0] m_data = 8'h00;
    logic       m_busy = 1'b0;
    logic [6:0] m_addr = 7'h00;

    lcd_status_reader #(
        .CLK_DIVIDE (CD),
        .SETUP_CYC  (SU),
        .HOLD_CYC   (HO),
        .POLL_GAP   (GAP),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iStart  (iStart),
        .iRS     (iRS),
        .iPoll   (iPoll),
        .oDone   (oDone),
        .oData   (oData),
        .oBusy   (oBusy),
        .oAddr   (oAddr),
        .oTimeout(oTimeout),
        .oActive (oActive),
        .LCD_RW  (LCD_RW),
        .LCD_EN  (LCD_EN),
        .LCD_RS  (LCD_RS),
        .LCD_DATA(LCD_DATA)
    );

    always #5 iCLK = ~iCLK;

    // LCD model: drives the bus only while RW=1; status reads step through stat_arr per EN pulse.
    assign LCD_DATA = LCD_RW ? (LCD_RS ? data_byte : status_cur) : 8'hzz;

    always_comb begin
        int k;
        k = stat_reads - stat_base;
        if (k > stat_n - 1) k = stat_n - 1;
        if (k < 0) k = 0;
        status_cur = stat_arr[k[2:0]];
    end

    always @(negedge iCLK) begin
        if (LCD_EN) en_run++;
        if (LCD_EN && !en_prev) en_pulses++;
        if (!LCD_EN && en_prev) begin
            if (en_run != CD + 1) bad_len++;
            en_run = 0;
            if (!LCD_RS) stat_reads++;
        end
        en_prev = LCD_EN;
        if (oDone) done_cnt++;
        if (oActive && !LCD_RW) gap_cycles++;
        if (LCD_RW && LCD_RS) rs_cycles++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Transaction-level prediction: each busy poll costs one full iteration; with the timeout
    // enabled polling stops at the first HOLD exit reached once TMO cycles have elapsed.
    function automatic vec_t predict(input logic rs, input logic poll, input logic [7:0] b,
                                     input int nbusy);
        vec_t v;
        int   nb;
        logic to;
        v.rs = rs; v.poll = poll; v.b = poll ? {1'b0, b[6:0]} : b; v.nbusy = nbusy;
        nb = poll ? nbusy : 0;
        to = 1'b0;
        if (TMO_EN && poll) begin
            for (int i = 0; i < nb; i++) begin
                if (BASE_LAT - 2 + i * ITER >= TMO) begin
                    nb = i;
                    to = 1'b1;
                    break;
                end
            end
        end
        v.exp_lat    = BASE_LAT + nb * ITER;
        v.exp_pulses = 1 + nb;
        v.exp_to     = to;
        if (rs && !poll) begin
            v.exp_data = b;
            v.exp_busy = m_busy;
            v.exp_addr = m_addr;
        end else begin
            v.exp_data = to ? {1'b1, b[6:0]} : v.b;
            v.exp_busy = v.exp_data[7];
            v.exp_addr = v.exp_data[6:0];
        end
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int lat, nb, p0, d0, g0, r0, bl0;
        nb = v.poll ? v.nbusy : 0;
        if (v.rs && !v.poll) begin
            data_byte = v.b;
            stat_arr[0] = 8'($urandom);
            stat_n = 1;
        end else begin
            data_byte = 8'($urandom);
            for (int i = 0; i < nb; i++) stat_arr[i] = {1'b1, v.b[6:0]};
            stat_arr[nb] = v.b;
            stat_n = nb + 1;
        end
        stat_base = stat_reads;
        p0 = en_pulses; d0 = done_cnt; g0 = gap_cycles; r0 = rs_cycles; bl0 = bad_len;

        @(negedge iCLK);
        iRS = v.rs; iPoll = v.poll; iStart = 1'b1;
        @(posedge iCLK);
        lat = -1;
        for (int k = 1; k <= BASE_LAT + nb * ITER + 20; k++) begin
            @(posedge iCLK);
            #1;
            if (k == 3) begin iRS = ~v.rs; iPoll = ~v.poll; end
            if (oDone) begin lat = k; break; end
        end
        iStart = 1'b0;
        check("latency", lat, v.exp_lat);
        check("done_rw", int'(LCD_RW), 0);
        check("done_active", int'(oActive), 0);
        check("data", int'(oData), int'(v.exp_data));
        check("busy", int'(oBusy), int'(v.exp_busy));
        check("addr", int'(oAddr), int'(v.exp_addr));
        check("timeout", int'(oTimeout), int'(v.exp_to));
        repeat (3) @(negedge iCLK);
        check("done_count", done_cnt - d0, 1);
        check("en_pulses", en_pulses - p0, v.exp_pulses);
        check("en_len_errors", bad_len - bl0, 0);
        check("gap_cycles", gap_cycles - g0, (v.exp_pulses - 1) * GAP);
        check("rs_cycles", rs_cycles - r0, (v.rs && !v.poll) ? SU + CD + 1 + HO : 0);
        $display("txn %0d rs=%0d poll=%0d byte=%02h nbusy=%0d lat=%0d data=%02h busy=%0d addr=%02h to=%0d",
                 txn_no, v.rs, v.poll, v.b, v.nbusy, lat, oData, oBusy, oAddr, oTimeout);
        txn_no++;
        m_data = v.exp_data; m_busy = v.exp_busy; m_addr = v.exp_addr;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab [5];
        vec_t v;
        int   d0, p0, seen;

        tab[0] = '{1'b1, 1'b0, 8'h41, 0, 8'h41, 1'b0, 7'h00, 22, 1, 1'b0};
        tab[1] = '{1'b0, 1'b0, 8'h8A, 0, 8'h8A, 1'b1, 7'h0A, 22, 1, 1'b0};
        tab[2] = '{1'b1, 1'b0, 8'hC3, 0, 8'hC3, 1'b1, 7'h0A, 22, 1, 1'b0};
        tab[3] = '{1'b1, 1'b1, 8'h05, 3, TMO_EN ? 8'h85 : 8'h05, TMO_EN, 7'h05,
                   TMO_EN ? 128 : 181, TMO_EN ? 3 : 4, TMO_EN};
        tab[4] = '{1'b1, 1'b0, 8'h41, 0, 8'h41, TMO_EN, 7'h05, 22, 1, 1'b0};

        // Reset state
        repeat (3) @(negedge iCLK);
        check("rst_en", int'(LCD_EN), 0);
        check("rst_rw", int'(LCD_RW), 0);
        check("rst_rs", int'(LCD_RS), 0);
        check("rst_done", int'(oDone), 0);
        check("rst_active", int'(oActive), 0);
        check("rst_data", int'(oData), 0);
        check("rst_busy_addr", int'({oBusy, oAddr}), 0);
        check("rst_timeout", int'(oTimeout), 0);
        iRST_N = 1'b1;
        repeat (2) @(negedge iCLK);

        for (int i = 0; i < 5; i++) run_txn(tab[i]);

        for (int i = 0; i < 20; i++) begin
            v = predict(1'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom),
                        $urandom_range(0, 2));
            run_txn(v);
        end

        // Level held high: exactly one transaction
        data_byte = 8'h33; d0 = done_cnt; p0 = en_pulses;
        @(negedge iCLK); iRS = 1'b1; iPoll = 1'b0; iStart = 1'b1;
        repeat (500) @(negedge iCLK);
        check("held_done", done_cnt - d0, 1);
        check("held_pulses", en_pulses - p0, 1);
        check("held_data", int'(oData), 8'h33);
        iStart = 1'b0;
        $display("txn %0d held-start done=%0d pulses=%0d data=%02h", txn_no, done_cnt - d0,
                 en_pulses - p0, oData);
        txn_no++;
        m_data = 8'h33;
        repeat (2) @(negedge iCLK);

        // Second rising edge during ENH is ignored
        data_byte = 8'h6C; d0 = done_cnt; p0 = en_pulses;
        iStart = 1'b1;
        repeat (6) @(negedge iCLK); iStart = 1'b0;
        repeat (2) @(negedge iCLK); iStart = 1'b1;
        repeat (60) @(negedge iCLK); iStart = 1'b0;
        check("reedge_done", done_cnt - d0, 1);
        check("reedge_pulses", en_pulses - p0, 1);
        $display("txn %0d second-edge done=%0d pulses=%0d", txn_no, done_cnt - d0, en_pulses - p0);
        txn_no++;
        m_data = 8'h6C;
        repeat (2) @(negedge iCLK);

        // Reset during the fifth EN-high cycle
        data_byte = 8'h5A; d0 = done_cnt; seen = 0;
        iStart = 1'b1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge iCLK);
            if (LCD_EN) seen = 1;
        end
        check("rst_mid_en_seen", seen, 1);
        repeat (4) @(negedge iCLK);
        iRST_N = 1'b0;
        #1;
        check("rst_mid_en", int'(LCD_EN), 0);
        check("rst_mid_rw", int'(LCD_RW), 0);
        check("rst_mid_active", int'(oActive), 0);
        check("rst_mid_data", int'(oData), 0);
        iStart = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST_N = 1'b1;
        repeat (30) @(negedge iCLK);
        check("rst_mid_no_done", done_cnt - d0, 0);
        $display("txn %0d reset-mid-enh done=%0d", txn_no, done_cnt - d0);
        txn_no++;
        m_data = 8'h00; m_busy = 1'b0; m_addr = 7'h00;
        run_txn(tab[0]);

        // Busy forever
        stat_arr[0] = 8'h8C; stat_n = 1; stat_base = stat_reads; d0 = done_cnt;
        @(negedge iCLK); iRS = 1'b0; iPoll = 1'b1; iStart = 1'b1;
`ifdef LCD_POLL_TIMEOUT_EN
        seen = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge iCLK);
            if (oDone) seen = 1;
        end
        iStart = 1'b0;
        check("tmo_done", seen, 1);
        check("tmo_flag", int'(oTimeout), 1);
        check("tmo_busy", int'(oBusy), 1);
        check("tmo_addr", int'(oAddr), 7'h0C);
        $display("txn %0d busy-forever done=%0d timeout=%0d busy=%0d", txn_no, seen, oTimeout, oBusy);
        txn_no++;
        m_data = 8'h8C; m_busy = 1'b1; m_addr = 7'h0C;
        run_txn(predict(1'b1, 1'b0, 8'h77, 0));
`else
        repeat (10000) @(negedge iCLK);
        iStart = 1'b0;
        check("poll_no_done", done_cnt - d0, 0);
        check("poll_still_active", int'(oActive), 1);
        check("poll_no_timeout", int'(oTimeout), 0);
        $display("txn %0d busy-forever done=%0d active=%0d", txn_no, done_cnt - d0, oActive);
        txn_no++;
        iRST_N = 1'b0;
        repeat (2) @(negedge iCLK);
        iRST_N = 1'b1;
        m_data = 8'h00; m_busy = 1'b0; m_addr = 7'h00;
        run_txn(predict(1'b0, 1'b0, 8'h2B, 0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
